av_config_sequencer: RTL and testbench

//  Boot-time configurator for the audio codec / video decoder 2-wire config bus (av_config_SCLK/SDAT).
//  - Walks an external command table of NUM_CMDS 24-bit words {dev_addr[7:0], reg[7:0], data[7:0]}.
//  - Serialises each word as one write transaction: START, 3 bytes + ACK slots, STOP.
//  - Sits between the system reset/boot logic and the board-level SDAT pad; the top level builds the open-drain pad from sdat_oe.

---
 rtl/av_config_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_av_config_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/av_config_sequencer.sv
// av_config_sequencer: boot-time writer for the codec/decoder 2-wire config bus.
// Walks an external table of {dev_addr, reg, data} words and sends each one as a
// START, three byte+ACK slots, STOP write. SDAT is open-drain via sdat_oe.
// Optional build macro AV_CONFIG_RETRY_EN: re-send a NACKed entry up to MAX_RETRY times.
module av_config_sequencer #(
  parameter int NUM_CMDS    = 16,
  parameter int QUARTER_DIV = 125,
  parameter int MAX_RETRY   = 3
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  output logic [((NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1)-1:0] cmd_index,
  input  logic [23:0]                                    cmd_word,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           nack_error,
  output logic                                           av_config_SCLK,
  output logic                                           sdat_oe,
  input  logic                                           sdat_in
);
  localparam int IW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int QW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CMDS - 1);
  localparam logic [QW-1:0] QTR_LAST  = QW'(QUARTER_DIV - 1);
  localparam logic [3:0]    ACK_SLOT  = 4'd8;
  localparam logic [1:0]    LAST_BYTE = 2'd2;

  if (NUM_CMDS < 1 || QUARTER_DIV < 2 || MAX_RETRY < 0) begin : g_bad_params
    $error("av_config_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_BIT, S_STOP, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          ack_fail_q, ack_fail_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic [23:0]   shift_q, shift_d;
  logic          bit_q, bit_d;

  logic tick, qtr_end, ack_slot, last_entry, retry_now;

  // A quarter ends when the divider wraps; a bit period ends on the fourth quarter.
  assign tick       = (qcnt_q == QTR_LAST);
  assign qtr_end    = tick && (phase_q == 2'd3);
  assign ack_slot   = (bit_cnt_q == ACK_SLOT);
  assign last_entry = (idx_q == LAST_IDX);

`ifdef AV_CONFIG_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;

  assign retry_now = (state_q == S_NEXT) && ack_fail_q && (retry_q < RETRY_MAX);

  // Re-send count for the current entry; cleared whenever the walk moves past it.
  always_comb begin
    retry_d = retry_q;
    if (retry_now)
      retry_d = retry_q + 1'b1;
    else if (state_q == S_NEXT)
      retry_d = '0;
  end

  // Retry counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`else
  assign retry_now = 1'b0;
`endif

  // Next-state logic: one write transaction per table entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (qtr_end) state_d = S_BIT;
      S_BIT:   if (qtr_end && ack_slot && byte_cnt_q == LAST_BYTE) state_d = S_STOP;
      S_STOP:  if (qtr_end) state_d = S_NEXT;
      S_NEXT:  state_d = (retry_now || !last_entry) ? S_LOAD : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Quarter timing, bit/byte counters, shift register, table index and status flags.
  always_comb begin
    qcnt_d     = '0;
    phase_d    = '0;
    shift_d    = shift_q;
    bit_d      = bit_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ack_fail_d = ack_fail_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    nack_d     = nack_q;
    // Timing restarts from Q0 on every state change and holds at zero in IDLE.
    if (state_q != S_IDLE && state_d == state_q) begin
      qcnt_d  = tick ? '0 : qcnt_q + 1'b1;
      phase_d = tick ? phase_q + 2'd1 : phase_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          nack_d = 1'b0;
          idx_d  = '0;
        end
      end
      S_LOAD: begin
        shift_d    = cmd_word;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        ack_fail_d = 1'b0;
      end
      S_BIT: begin
        // Hold the current data bit for Q1..Q3 while the register advances.
        if (!ack_slot && phase_q == 2'd0 && tick) begin
          bit_d   = shift_q[23];
          shift_d = {shift_q[22:0], 1'b0};
        end
        if (ack_slot && qtr_end && sdat_in)
          ack_fail_d = 1'b1;
        if (qtr_end) begin
          if (ack_slot) begin
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_NEXT: begin
        if (!retry_now) begin
          if (ack_fail_q)
            nack_d = 1'b1;
          if (last_entry) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            idx_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Bus pin decode; everywhere outside START/BIT/STOP the bus idles SCLK high, SDAT released.
  always_comb begin
    av_config_SCLK = 1'b1;
    sdat_oe        = 1'b0;
    case (state_q)
      S_START: sdat_oe = phase_q[1];
      S_BIT: begin
        av_config_SCLK = phase_q[1];
        if (!ack_slot)
          sdat_oe = (phase_q == 2'd0) ? ~shift_q[23] : ~bit_q;
      end
      S_STOP: begin
        av_config_SCLK = phase_q[1];
        sdat_oe        = (phase_q != 2'd3);
      end
      default: ;
    endcase
  end

  // Control registers: FSM, timing, counters and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ack_fail_q <= 1'b0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ack_fail_q <= ack_fail_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  // Data registers; their contents only reach the pins inside BIT, after LOAD has filled them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    bit_q   <= bit_d;
  end

  assign cmd_index  = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack_error = nack_q;

endmodule

// File: tb/tb_av_config_sequencer.sv
// Bench for av_config_sequencer: a 2-wire slave model decodes the bus and ACKs or
// NACKs per a programmable pattern; a table-walk model predicts the write sequence.
module tb_av_config_sequencer;
  localparam int NUM_CMDS    = 2;
  localparam int QUARTER_DIV = 2;
  localparam int MAX_RETRY   = 3;
  localparam int CMD_CYC     = 116 * QUARTER_DIV + 2;
`ifdef AV_CONFIG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [0:0]  cmd_index;
  logic [23:0] cmd_word;
  logic        busy, done, nack_error, scl, sdat_oe, sdat_in;
  logic [23:0] table_mem [NUM_CMDS];

  // Slave model state
  logic        slv_clr = 1'b1;
  logic        slv_pull = 1'b0;
  logic        slv_prev_scl = 1'b1, slv_prev_sda = 1'b1, slv_active = 1'b0;
  logic [3:0]  slv_bits = '0, slv_cur = '0, slv_xfer = '0;
  logic [7:0]  slv_byte = '0, slv_nbytes = '0;
  logic [23:0] slv_word = '0;
  logic [15:0] nack_mask = '0;
  logic [1:0]  nack_byte = 2'd3;
  logic [31:0] got_q [$];

  int checks = 0;
  int failures = 0;

  av_config_sequencer #(
    .NUM_CMDS(NUM_CMDS), .QUARTER_DIV(QUARTER_DIV), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_word(cmd_word),
    .busy(busy), .done(done), .nack_error(nack_error), .av_config_SCLK(scl),
    .sdat_oe(sdat_oe), .sdat_in(sdat_in)
  );

  assign cmd_word = table_mem[cmd_index];
  // Open-drain pad: low if either the master or the slave pulls it.
  assign sdat_in = ~sdat_oe & ~slv_pull;

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Slave: decodes START/STOP, shifts bits on SCLK rise, drives ACK during the 9th slot.
  always @(negedge clk) begin
    if (slv_clr) begin
      slv_active   <= 1'b0;
      slv_pull     <= 1'b0;
      slv_xfer     <= '0;
      slv_bits     <= '0;
      slv_nbytes   <= '0;
      slv_prev_scl <= 1'b1;
      slv_prev_sda <= 1'b1;
      got_q.delete();
    end else begin
      slv_prev_scl <= scl;
      slv_prev_sda <= sdat_in;
      if (scl && slv_prev_scl && slv_prev_sda && !sdat_in) begin
        slv_active <= 1'b1;
        slv_bits   <= '0;
        slv_nbytes <= '0;
        slv_word   <= '0;
        slv_pull   <= 1'b0;
        slv_cur    <= slv_xfer;
        slv_xfer   <= slv_xfer + 4'd1;
      end else if (scl && slv_prev_scl && !slv_prev_sda && sdat_in) begin
        if (slv_active) got_q.push_back({slv_nbytes, slv_word});
        slv_active <= 1'b0;
      end else if (scl && !slv_prev_scl && slv_active) begin
        if (slv_bits < 4'd8) begin
          slv_byte <= {slv_byte[6:0], sdat_in};
          slv_bits <= slv_bits + 4'd1;
        end else begin
          slv_bits   <= '0;
          slv_word   <= {slv_word[15:0], slv_byte};
          slv_nbytes <= slv_nbytes + 8'd1;
        end
      end else if (!scl && slv_prev_scl && slv_active) begin
        slv_pull <= (slv_bits == 4'd8) && !(nack_mask[slv_cur] && (slv_nbytes == 8'(nack_byte)));
      end
    end
  end

  // One table walk: predict the write sequence, run it, compare bus, timing and status.
  task automatic run_walk(input string tag, input logic [23:0] w0, input logic [23:0] w1,
                          input logic [15:0] mask, input logic [1:0] nb, input int pulse_at);
    logic [23:0] words [NUM_CMDS];
    logic [23:0] exp_w [$];
    int          exp_e [$];
    bit          exp_nack, fail, again;
    int          xf, tries, n, k;
    words[0] = w0;
    words[1] = w1;
    exp_nack = 1'b0;
    xf = 0;
    for (int e = 0; e < NUM_CMDS; e++) begin
      tries = 0;
      again = 1'b1;
      while (again) begin
        exp_w.push_back(words[e]);
        exp_e.push_back(e);
        fail = (nb != 2'd3) && mask[xf];
        xf++;
        if (fail && RETRY && tries < MAX_RETRY) begin
          tries++;
        end else begin
          again = 1'b0;
          if (fail) exp_nack = 1'b1;
        end
      end
    end

    table_mem[0] = w0;
    table_mem[1] = w1;
    nack_mask = mask;
    nack_byte = nb;
    slv_clr = 1'b1;
    repeat (2) @(negedge clk);
    slv_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      if (pulse_at > 0 && n == pulse_at + 1 && (n - 1) / CMD_CYC < exp_e.size())
        check_eq($sformatf("%s_idx_after_pulse", tag), 32'(cmd_index), 32'(exp_e[(n - 1) / CMD_CYC]));
      start = (pulse_at > 0 && n == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq($sformatf("%s_busy_cycles", tag), 32'(n), 32'(exp_w.size() * CMD_CYC));
    check_eq($sformatf("%s_done", tag), 32'(done), 32'd1);
    check_eq($sformatf("%s_nack_error", tag), 32'(nack_error), 32'(exp_nack));
    check_eq($sformatf("%s_idx_at_done", tag), 32'(cmd_index), 32'd0);
    check_eq($sformatf("%s_bus_idle", tag), {30'd0, scl, sdat_oe}, 32'd2);
    check_eq($sformatf("%s_num_writes", tag), 32'(got_q.size()), 32'(exp_w.size()));
    for (k = 0; k < exp_w.size(); k++)
      check_eq($sformatf("%s_write%0d", tag, k),
               (k < got_q.size()) ? got_q[k] : 32'hFFFF_FFFF, {8'd3, exp_w[k]});
    @(negedge clk);
    check_eq($sformatf("%s_done_level", tag), {30'd0, done, busy}, 32'd2);
  endtask

  initial begin
    int bad_scl, bad_oe, bad_busy, bad_done;
    logic [23:0] r0, r1;
    table_mem[0] = 24'h34_0A_5C;
    table_mem[1] = 24'h40_1F_00;
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", 32'(scl), 32'd1);
    check_eq("rst_oe", 32'(sdat_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_nack", 32'(nack_error), 32'd0);
    check_eq("rst_idx", 32'(cmd_index), 32'd0);
    reset = 1'b0;

    bad_scl = 0; bad_oe = 0; bad_busy = 0; bad_done = 0;
    repeat (1000) begin
      @(negedge clk);
      if (scl !== 1'b1)     bad_scl++;
      if (sdat_oe !== 1'b0) bad_oe++;
      if (busy !== 1'b0)    bad_busy++;
      if (done !== 1'b0)    bad_done++;
    end
    check_eq("idle_sclk_bad", 32'(bad_scl), 32'd0);
    check_eq("idle_oe_bad", 32'(bad_oe), 32'd0);
    check_eq("idle_busy_bad", 32'(bad_busy), 32'd0);
    check_eq("idle_done_bad", 32'(bad_done), 32'd0);

    run_walk("basic", 24'h34_0A_5C, 24'h40_1F_00, 16'h0000, 2'd3, 0);
    run_walk("nack_e0_b2", 24'h34_0A_5C, 24'h40_1F_00, 16'h0001, 2'd2, 0);
    run_walk("nack_persist", 24'h34_0A_5C, 24'h40_1F_00, 16'h000F, 2'd2, 0);
    run_walk("nack_e1_once", 24'h34_0A_5C, 24'h40_1F_00, 16'h0002, 2'd2, 0);
    run_walk("start_ignored", 24'h34_0A_5C, 24'h40_1F_00, 16'h0000, 2'd3, 300);

    // Reset in the middle of entry 1's first byte.
    table_mem[0] = 24'h34_0A_5C;
    table_mem[1] = 24'h40_1F_00;
    nack_mask = '0;
    nack_byte = 2'd3;
    slv_clr = 1'b1;
    repeat (2) @(negedge clk);
    slv_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    check_eq("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_sclk", 32'(scl), 32'd1);
    check_eq("midrst_oe", 32'(sdat_oe), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_idx", 32'(cmd_index), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_walk("after_reset", 24'h34_0A_5C, 24'h40_1F_00, 16'h0000, 2'd3, 0);

    for (int it = 0; it < 8; it++) begin
      r0 = 24'($urandom);
      r0[16] = 1'b0;
      r1 = 24'($urandom);
      r1[16] = 1'b0;
      run_walk($sformatf("rnd%0d", it), r0, r1, 16'($urandom & $urandom),
               2'($urandom_range(0, 3)), (it % 2 == 1) ? int'($urandom_range(10, 200)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
